frog_progress_tracker: RTL

Game-progress tracker that drives the three status inputs of the game state machine (nest reached, level complete, game lost) and consumes its control outputs (level number, point reset, frog-set acknowledge). It sits between the frog/hazard collision logic and the game state machine. It keeps nest occupancy, remaining lives and a per-frog countdown timer, and turns raw collision pulses into the handshaked status signals the state machine expects.

---
 rtl/frog_progress_tracker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/frog_progress_tracker.sv
// Frog game progress tracker: nest occupancy, lives and per-frog timer.
// Turns raw collision pulses into the handshaked status lines of the
// game state machine.
//
// Ports:
//   SC_STATEMACHINEGAME_CLOCK_50             system clock
//   SC_STATEMACHINEGAME_RESET_InHigh         async reset, active-high
//   SC_STATEMACHINEGAME_Level_Out            level / screen code (0..3 = play)
//   SC_STATEMACHINEGAME_RESET_FromGame_Point point reset (bit 0)
//   SC_STATEMACHINEGAME_SET_FrogGame         nest acknowledge (bit 0)
//   frog_nest_hit                            one-hot nest entry pulse
//   frog_hazard_hit                          frog hit / drowned pulse
//   SC_STATEMACHINEGAME_WinF_InLow           nest reached, active-low
//   SC_STATEMACHINEGAME_WinL_InLow           level complete, active-high
//   SC_STATEMACHINEGAME_Lose_InLow           game lost, active-high
//   nest_mask                                nest occupancy flags
//   lives                                    lives remaining
//   time_left                                seconds left for this frog
//   frog_respawn                             one-cycle respawn pulse
module frog_progress_tracker #(
    parameter int NEST_COUNT    = 5,
    parameter int LIVES_INIT    = 3,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_BASE     = 30,
    parameter int TIME_STEP     = 5
) (
    input  logic                  SC_STATEMACHINEGAME_CLOCK_50,
    input  logic                  SC_STATEMACHINEGAME_RESET_InHigh,
    input  logic [3:0]            SC_STATEMACHINEGAME_Level_Out,
    input  logic [1:0]            SC_STATEMACHINEGAME_RESET_FromGame_Point,
    input  logic [1:0]            SC_STATEMACHINEGAME_SET_FrogGame,
    input  logic [NEST_COUNT-1:0] frog_nest_hit,
    input  logic                  frog_hazard_hit,
    output logic                  SC_STATEMACHINEGAME_WinF_InLow,
    output logic                  SC_STATEMACHINEGAME_WinL_InLow,
    output logic                  SC_STATEMACHINEGAME_Lose_InLow,
    output logic [NEST_COUNT-1:0] nest_mask,
    output logic [1:0]            lives,
    output logic [5:0]            time_left,
    output logic                  frog_respawn
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        NEST_REQ,
        LEVEL_DONE,
        DEAD
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;

    logic            point_rst;
    logic            ack;
    logic            playing;
    logic [7:0]      reload_calc;
    logic [5:0]      reload_time;
    logic [NEST_COUNT-1:0] nest_sel;
    logic            nest_any;
    logic            nest_taken;
    logic            tick;
    logic            expire;
    logic            death;

    assign point_rst = SC_STATEMACHINEGAME_RESET_FromGame_Point[0];
    assign ack       = SC_STATEMACHINEGAME_SET_FrogGame[0];
    assign playing   = (SC_STATEMACHINEGAME_Level_Out[3:2] == 2'b00);

    assign reload_calc = 8'(TIME_BASE)
                       - 8'(SC_STATEMACHINEGAME_Level_Out[1:0]) * 8'(TIME_STEP);
    assign reload_time = reload_calc[5:0];

    // x & -x isolates the lowest set bit, so the lowest nest index wins
    assign nest_sel   = frog_nest_hit & (-frog_nest_hit);
    assign nest_any   = |frog_nest_hit;
    assign nest_taken = |(nest_sel & nest_mask);

    // Expiry is the 1 -> 0 step of the seconds counter
    assign tick   = (prescaler == P_LAST);
    assign expire = tick && (time_left == 6'd1);
    assign death  = frog_hazard_hit || expire || (nest_any && nest_taken);

    always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or
                posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
        if (SC_STATEMACHINEGAME_RESET_InHigh) begin
            state                          <= IDLE;
            SC_STATEMACHINEGAME_WinF_InLow <= 1'b1;
            SC_STATEMACHINEGAME_WinL_InLow <= 1'b0;
            SC_STATEMACHINEGAME_Lose_InLow <= 1'b0;
            nest_mask                      <= '0;
            lives                          <= 2'(LIVES_INIT);
            time_left                      <= '0;
            frog_respawn                   <= 1'b0;
            prescaler                      <= '0;
        end else if (point_rst) begin
            state                          <= IDLE;
            SC_STATEMACHINEGAME_WinF_InLow <= 1'b1;
            SC_STATEMACHINEGAME_WinL_InLow <= 1'b0;
            SC_STATEMACHINEGAME_Lose_InLow <= 1'b0;
            nest_mask                      <= '0;
            lives                          <= 2'(LIVES_INIT);
            time_left                      <= '0;
            frog_respawn                   <= 1'b0;
            prescaler                      <= '0;
        end else begin
            frog_respawn <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (playing) begin
                        state     <= PLAY;
                        time_left <= reload_time;
                        prescaler <= '0;
                    end
                end
                PLAY: begin
                    if (!playing) begin
                        // Leaving play freezes timer and prescaler
                        state <= IDLE;
                    end else if (death) begin
                        prescaler <= '0;
                        if (lives == 2'd1) begin
                            lives                          <= 2'd0;
                            SC_STATEMACHINEGAME_Lose_InLow <= 1'b1;
                            state                          <= DEAD;
                        end else begin
                            lives        <= lives - 2'd1;
                            frog_respawn <= 1'b1;
                            time_left    <= reload_time;
                        end
                    end else begin
                        if (tick) begin
                            prescaler <= '0;
                            time_left <= time_left - 6'd1;
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                        if (nest_any) begin
                            nest_mask                      <= nest_mask | nest_sel;
                            SC_STATEMACHINEGAME_WinF_InLow <= 1'b0;
                            state                          <= NEST_REQ;
                        end
                    end
                end
                NEST_REQ: begin
                    if (ack) begin
                        SC_STATEMACHINEGAME_WinF_InLow <= 1'b1;
                        frog_respawn                   <= 1'b1;
                        time_left                      <= reload_time;
                        prescaler                      <= '0;
                        if (&nest_mask) begin
                            SC_STATEMACHINEGAME_WinL_InLow <= 1'b1;
                            state                          <= LEVEL_DONE;
                        end else begin
                            state <= PLAY;
                        end
                    end
                end
                LEVEL_DONE: state <= LEVEL_DONE;
                DEAD:       state <= DEAD;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule
